// File: rtl/shadow_err_alert_ctrl.sv
// Shadow-register error aggregation: sticky recoverable/fatal status, a saturating
// recoverable-error counter, and two independent four-phase alert handshakes.
module shadow_err_alert_ctrl #(
  parameter int NumRegs = 4,
  parameter int CntW    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumRegs-1:0] err_update_i,
  input  logic [NumRegs-1:0] err_storage_i,
  input  logic [NumRegs-1:0] recov_clr_i,
  input  logic               cnt_clr_i,
  input  logic               alert_test_recov_i,
  input  logic               alert_test_fatal_i,
  output logic               recov_req_o,
  input  logic               recov_ack_i,
  output logic               fatal_req_o,
  input  logic               fatal_ack_i,
  output logic [NumRegs-1:0] recov_status_o,
  output logic [NumRegs-1:0] fatal_status_o,
  output logic [CntW-1:0]    recov_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKLO = 2'd2
  } hs_state_e;

  localparam logic [CntW-1:0] CntOne = CntW'(1);

  hs_state_e recov_state;
  hs_state_e fatal_state;
  logic      recov_pend;
  logic      fatal_pend;

  logic any_update;
  logic any_fatal;
  logic recov_trig;
  logic fatal_trig;

  assign any_update = |err_update_i;
  assign any_fatal  = |fatal_status_o;
  assign recov_trig = any_update | alert_test_recov_i;
  assign fatal_trig = (|err_storage_i) | alert_test_fatal_i;

  // Holds at all-ones instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    logic [CntW-1:0] r;
    if (&v) r = v;
    else    r = v + CntOne;
    return r;
  endfunction

  // Set has priority over clear so an error in the clearing cycle is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      recov_status_o <= '0;
      fatal_status_o <= '0;
    end else begin
      recov_status_o <= (recov_status_o & ~recov_clr_i) | err_update_i;
      fatal_status_o <= fatal_status_o | err_storage_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      recov_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      recov_cnt_o <= any_update ? CntOne : '0;
    end else if (any_update) begin
      recov_cnt_o <= sat_inc(recov_cnt_o);
    end
  end

  // Triggers arriving mid-handshake collapse into one pending follow-up handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      recov_state <= IDLE;
      recov_pend  <= 1'b0;
      recov_req_o <= 1'b0;
    end else begin
      case (recov_state)
        IDLE: begin
          if (recov_trig || recov_pend) begin
            recov_state <= REQ;
            recov_req_o <= 1'b1;
            recov_pend  <= 1'b0;
          end
        end
        REQ: begin
          if (recov_trig) recov_pend <= 1'b1;
          if (recov_ack_i) begin
            recov_state <= ACKLO;
            recov_req_o <= 1'b0;
          end
        end
        ACKLO: begin
          if (recov_trig) recov_pend <= 1'b1;
          if (!recov_ack_i) recov_state <= IDLE;
        end
        default: begin
          recov_state <= IDLE;
          recov_req_o <= 1'b0;
        end
      endcase
    end
  end

  // A latched storage error keeps the fatal alert re-firing until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fatal_state <= IDLE;
      fatal_pend  <= 1'b0;
      fatal_req_o <= 1'b0;
    end else begin
      case (fatal_state)
        IDLE: begin
          if (fatal_trig || fatal_pend || any_fatal) begin
            fatal_state <= REQ;
            fatal_req_o <= 1'b1;
            fatal_pend  <= 1'b0;
          end
        end
        REQ: begin
          if (fatal_trig) fatal_pend <= 1'b1;
          if (fatal_ack_i) begin
            fatal_state <= ACKLO;
            fatal_req_o <= 1'b0;
          end
        end
        ACKLO: begin
          if (fatal_trig) fatal_pend <= 1'b1;
          if (!fatal_ack_i) fatal_state <= IDLE;
        end
        default: begin
          fatal_state <= IDLE;
          fatal_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shadow_err_alert_ctrl.sv
// Scoreboard bench for shadow_err_alert_ctrl: expectations are queued with each
// cycle's stimulus and checked just after the following rising edge.
module tb_shadow_err_alert_ctrl;

  localparam int NumRegs = 4;

  localparam int S_RREQ  = 0;
  localparam int S_FREQ  = 1;
  localparam int S_RSTAT = 2;
  localparam int S_FSTAT = 3;
  localparam int S_RCNT  = 4;
  localparam int S_CNT2  = 5;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [NumRegs-1:0] err_update = '0, err_storage = '0, recov_clr = '0;
  logic cnt_clr = 1'b0, test_recov = 1'b0, test_fatal = 1'b0;
  logic recov_ack = 1'b0, fatal_ack = 1'b0;
  logic recov_req, fatal_req;
  logic [NumRegs-1:0] recov_status, fatal_status;
  logic [7:0] recov_cnt;

  logic [NumRegs-1:0] err_update2 = '0, zero_n = '0;
  logic cnt_clr2 = 1'b0, zero1 = 1'b0;
  logic recov_req2, fatal_req2;
  logic [NumRegs-1:0] recov_status2, fatal_status2;
  logic [1:0] recov_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  string       tag_q[$];
  int          sel_q[$];
  int unsigned val_q[$];

  always #5 clk = ~clk;

  shadow_err_alert_ctrl #(.NumRegs(NumRegs), .CntW(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .err_update_i(err_update), .err_storage_i(err_storage), .recov_clr_i(recov_clr),
    .cnt_clr_i(cnt_clr), .alert_test_recov_i(test_recov), .alert_test_fatal_i(test_fatal),
    .recov_req_o(recov_req), .recov_ack_i(recov_ack),
    .fatal_req_o(fatal_req), .fatal_ack_i(fatal_ack),
    .recov_status_o(recov_status), .fatal_status_o(fatal_status), .recov_cnt_o(recov_cnt)
  );

  shadow_err_alert_ctrl #(.NumRegs(NumRegs), .CntW(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni),
    .err_update_i(err_update2), .err_storage_i(zero_n), .recov_clr_i(zero_n),
    .cnt_clr_i(cnt_clr2), .alert_test_recov_i(zero1), .alert_test_fatal_i(zero1),
    .recov_req_o(recov_req2), .recov_ack_i(zero1),
    .fatal_req_o(fatal_req2), .fatal_ack_i(zero1),
    .recov_status_o(recov_status2), .fatal_status_o(fatal_status2), .recov_cnt_o(recov_cnt2)
  );

  task automatic chk_eq(input string tag, input int unsigned got, input int unsigned want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int unsigned obs(input int sel);
    case (sel)
      S_RREQ:  return 32'(recov_req);
      S_FREQ:  return 32'(fatal_req);
      S_RSTAT: return 32'(recov_status);
      S_FSTAT: return 32'(fatal_status);
      S_RCNT:  return 32'(recov_cnt);
      default: return 32'(recov_cnt2);
    endcase
  endfunction

  task automatic expect_nx(input string tag, input int sel, input int unsigned val);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    val_q.push_back(val);
  endtask

  // Advance one clock and score everything queued for this edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    while (tag_q.size() > 0) begin
      string t;
      int s;
      int unsigned v;
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      v = val_q.pop_front();
      chk_eq(t, obs(s), v);
    end
  endtask

  task automatic expect_reqs(input string tag, input int unsigned r, input int unsigned f);
    expect_nx({tag, "_rreq"}, S_RREQ, r);
    expect_nx({tag, "_freq"}, S_FREQ, f);
  endtask

  initial begin
    // Reset values
    expect_reqs("rst", 0, 0);
    expect_nx("rst_rstat", S_RSTAT, 0);
    expect_nx("rst_fstat", S_FSTAT, 0);
    expect_nx("rst_rcnt", S_RCNT, 0);
    expect_nx("rst_cnt2", S_CNT2, 0);
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Single update error, ack three cycles later
    err_update = 4'b0010;
    expect_reqs("t1_c1", 1, 0);
    expect_nx("t1_rstat", S_RSTAT, 4'b0010);
    expect_nx("t1_rcnt", S_RCNT, 1);
    cyc();
    err_update = '0;
    expect_reqs("t1_c2", 1, 0);
    cyc();
    expect_reqs("t1_c3", 1, 0);
    cyc();
    recov_ack = 1'b1;
    expect_reqs("t1_ack", 0, 0);
    cyc();
    recov_ack = 1'b0;
    expect_reqs("t1_acklo", 0, 0);
    cyc();
    expect_reqs("t1_idle", 0, 0);
    expect_nx("t1_rcnt_end", S_RCNT, 1);
    expect_nx("t1_rstat_end", S_RSTAT, 4'b0010);
    cyc();
    recov_ack = 1'b1;
    expect_reqs("idle_ack_ign", 0, 0);
    cyc();
    recov_ack = 1'b0;
    expect_reqs("idle_ack_ign2", 0, 0);
    cyc();

    // Clear status and counter, then two extra triggers during REQ
    recov_clr = 4'b1111;
    cnt_clr = 1'b1;
    expect_nx("clr_rstat", S_RSTAT, 0);
    expect_nx("clr_rcnt", S_RCNT, 0);
    cyc();
    recov_clr = '0;
    cnt_clr = 1'b0;
    err_update = 4'b0001;
    expect_reqs("t2_c1", 1, 0);
    expect_nx("t2_cnt1", S_RCNT, 1);
    cyc();
    expect_nx("t2_cnt2", S_RCNT, 2);
    expect_reqs("t2_c2", 1, 0);
    cyc();
    err_update = '0;
    expect_reqs("t2_c3", 1, 0);
    cyc();
    err_update = 4'b0001;
    expect_nx("t2_cnt3", S_RCNT, 3);
    cyc();
    err_update = '0;
    recov_ack = 1'b1;
    expect_reqs("t2_ack", 0, 0);
    cyc();
    recov_ack = 1'b0;
    expect_reqs("t2_acklo", 0, 0);
    cyc();
    expect_reqs("t2_pend_req", 1, 0);
    cyc();
    recov_ack = 1'b1;
    expect_reqs("t2_ack2", 0, 0);
    cyc();
    recov_ack = 1'b0;
    expect_reqs("t2_acklo2", 0, 0);
    cyc();
    expect_reqs("t2_no_third", 0, 0);
    expect_nx("t2_cnt_total", S_RCNT, 3);
    cyc();

    // Set wins over clear; clear alone next cycle
    err_update = 4'b0010;
    recov_clr = 4'b0010;
    expect_nx("setclr_same", S_RSTAT, 4'b0011);
    expect_nx("setclr_cnt", S_RCNT, 4);
    cyc();
    err_update = '0;
    expect_nx("clr_alone", S_RSTAT, 4'b0001);
    cyc();
    recov_clr = '0;
    recov_ack = 1'b1;
    cyc();
    recov_ack = 1'b0;
    cyc();
    expect_reqs("t3_idle", 0, 0);
    cyc();

    // Fatal test pulse: one handshake, no sticky state
    test_fatal = 1'b1;
    expect_reqs("tf_c1", 0, 1);
    expect_nx("tf_fstat", S_FSTAT, 0);
    cyc();
    test_fatal = 1'b0;
    expect_reqs("tf_c2", 0, 1);
    cyc();
    fatal_ack = 1'b1;
    expect_reqs("tf_ack", 0, 0);
    cyc();
    fatal_ack = 1'b0;
    expect_reqs("tf_acklo", 0, 0);
    cyc();
    expect_reqs("tf_once", 0, 0);
    cyc();
    expect_reqs("tf_once2", 0, 0);
    expect_nx("tf_fstat_end", S_FSTAT, 0);
    cyc();

    // Recoverable test pulse: handshake without status or count change
    test_recov = 1'b1;
    expect_reqs("tr_c1", 1, 0);
    expect_nx("tr_rstat", S_RSTAT, 4'b0001);
    expect_nx("tr_rcnt", S_RCNT, 4);
    cyc();
    test_recov = 1'b0;
    recov_ack = 1'b1;
    cyc();
    recov_ack = 1'b0;
    cyc();
    expect_reqs("tr_done", 0, 0);
    cyc();

    // Simultaneous triggers; fatal re-signals after every handshake
    err_update = 4'b0100;
    err_storage = 4'b1000;
    expect_reqs("both_c1", 1, 1);
    expect_nx("both_fstat", S_FSTAT, 4'b1000);
    expect_nx("both_rstat", S_RSTAT, 4'b0101);
    expect_nx("both_cnt", S_RCNT, 5);
    cyc();
    err_update = '0;
    err_storage = '0;
    recov_ack = 1'b1;
    fatal_ack = 1'b1;
    expect_reqs("both_ack", 0, 0);
    cyc();
    recov_ack = 1'b0;
    fatal_ack = 1'b0;
    expect_reqs("both_acklo", 0, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      expect_reqs("resig_req", 0, 1);
      expect_nx("resig_fstat", S_FSTAT, 4'b1000);
      cyc();
      fatal_ack = 1'b1;
      expect_reqs("resig_ack", 0, 0);
      cyc();
      fatal_ack = 1'b0;
      expect_reqs("resig_acklo", 0, 0);
      cyc();
    end

    // Reset mid-handshake aborts both FSMs
    err_update = 4'b0001;
    expect_reqs("pre_rst", 1, 1);
    expect_nx("pre_rst_cnt", S_RCNT, 6);
    cyc();
    err_update = '0;
    rst_ni = 1'b0;
    #1;
    chk_eq("async_rreq", 32'(recov_req), 0);
    chk_eq("async_freq", 32'(fatal_req), 0);
    chk_eq("async_fstat", 32'(fatal_status), 0);
    chk_eq("async_rstat", 32'(recov_status), 0);
    chk_eq("async_rcnt", 32'(recov_cnt), 0);
    expect_reqs("in_rst", 0, 0);
    cyc();
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_reqs("post_rst", 0, 0);
      expect_nx("post_rst_fstat", S_FSTAT, 0);
      cyc();
    end

    // Narrow counter saturates at 3; clear with increment gives 1
    err_update2 = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      expect_nx("cnt2_sat", S_CNT2, (k > 3) ? 3 : k);
      cyc();
    end
    cnt_clr2 = 1'b1;
    expect_nx("cnt2_clr_inc", S_CNT2, 1);
    cyc();
    err_update2 = '0;
    expect_nx("cnt2_clr_only", S_CNT2, 0);
    cyc();
    cnt_clr2 = 1'b0;

    // Wide counter saturates at 255 without wrapping
    err_update = 4'b0001;
    for (int k = 1; k <= 260; k++) begin
      expect_nx("cnt8_sat", S_RCNT, (k > 255) ? 255 : k);
      cyc();
    end
    err_update = '0;
    cnt_clr = 1'b1;
    expect_nx("cnt8_clr", S_RCNT, 0);
    cyc();
    cnt_clr = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
